mdu_iterative: RTL and testbench
================================

# mdu_iterative

Parametrised iterative multiply/divide unit for the EX stage. It is the successor to the fixed-latency behavioural HI/LO unit. Multiply uses a radix-2 shift-add datapath and divide uses a restoring radix-2 datapath, one bit per cycle. Results commit to HI/LO atomically on completion, so an in-flight operation can be cancelled by an exception flush without corrupting architectural HI/LO.

## Interface
- WIDTH, 32, operand / HI / LO width (≥4)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only when busy=0
- op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO, others no-op
- rs  in  WIDTH  operand A (dividend, multiplicand, MT source)
- rt  in  WIDTH  operand B (divisor, multiplier)
- cancel  in  1  abort in-flight operation (exception flush)
- hi  out  WIDTH  architectural HI, registered
- lo  out  WIDTH  architectural LO, registered
- busy  out  1  unit occupied; the pipeline stalls MF*/MT*/MD ops while high
- done  out  1  one-cycle pulse after commit of a long op

## Operation
- States: IDLE, MUL, DIV, FIX.
- Accept condition: start & ~busy & ~cancel. start while busy is ignored; the pipeline guarantees it does not happen.
- MTHI/MTLO:
  - hi (or lo) ← rs at the accepting edge.
  - State stays IDLE; busy and done are not asserted.
- DIV/DIVU with rt=0:
  - Accepted as a no-op: HI/LO unchanged, stays IDLE, no busy, no done.
- Long ops (0–7, divisor nonzero), at accept:
  - Latch |rs| and |rt| into internal registers (raw values for unsigned ops).
  - Latch the sign flags and op class.
  - Clear the partial result and set count=WIDTH.
  - Go to MUL (ops 0,1,4–7) or DIV (2,3).
- MUL: each cycle, if multiplier LSB=1 add the multiplicand into the upper half of the 2·WIDTH accumulator, then shift right 1. Decrement count; at count=1 go to FIX.
- DIV: each cycle, shift {rem,quo} left 1 and trial-subtract the divisor.
  - If non-negative: keep the difference and set quo LSB=1.
  - Else: restore.
  - Decrement count; at count=1 go to FIX.
- FIX (one cycle, commit at its edge):
  - MULT/MULTU: {hi,lo} ← product, negated if sign(rs)≠sign(rt) for signed ops.
  - MADD*/MSUB*: {hi,lo} ← {hi,lo} ± signed-corrected product, mod 2^(2·WIDTH). No overflow detection.
  - DIV: lo ← quotient truncated toward zero; hi ← remainder with the sign of the dividend.
  - DIV of MIN by −1 yields lo=MIN, hi=0 (natural wrap, no special case).
  - DIVU: unsigned quotient and remainder.
  - Then return to IDLE and set done=1 for the next cycle.
- cancel while state≠IDLE:
  - Next edge returns to IDLE; hi/lo untouched; done stays 0.
  - cancel in IDLE is ignored, except that it blocks acceptance of a coincident start.
- reset (any state, including mid-operation): state=IDLE, hi=0, lo=0, done=0, internal counters/registers cleared.

## Timing
- busy = (state≠IDLE) | (start & op∈{0..7} & ~(op∈{2,3} & rt=0) & ~cancel). The combinational term stalls a dependent MF* issued right behind the start.
- Long op accepted in cycle 0:
  - MUL/DIV occupy cycles 1..WIDTH; FIX is cycle WIDTH+1.
  - hi/lo update at the end of cycle WIDTH+1.
  - busy is high in cycles 0..WIDTH+1 (WIDTH+2 cycles). busy=0 and done=1 in cycle WIDTH+2.
- A new start is accepted in cycle WIDTH+2 (back-to-back, no bubble).
- Reset values: hi=0, lo=0, done=0, busy=0 when start=0.
- MTHI/MTLO: the new value is visible on hi/lo the cycle after accept.
- Cancel asserted in cycle k (1≤k≤WIDTH+1): busy=0 in cycle k+1. A cancel coinciding with the FIX cycle also suppresses the commit.

## Test plan
- WIDTH=32, MULT rs=0xFFFFFFFE, rt=3 → busy high 34 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse exactly 1 cycle.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU with rt=0 → busy never high, hi/lo unchanged.
- MTHI 5, MTLO 7, then MADDU rs=0xFFFFFFFF, rt=2 → hi=7, lo=5. Then MTHI 0, MTLO 0, MSUB 1×1 → hi=lo=0xFFFFFFFF.
- MULT started with hi=0x11, lo=0x22, cancel in cycle 10 → busy low in cycle 11, no done, hi=0x11, lo=0x22. MULTU 3×4 accepted in cycle 11 → lo=12, hi=0.
- reset asserted in cycle 5 of a DIV → next cycle hi=lo=0, busy=0, done=0. start=1 with cancel=1 in IDLE → not accepted.
- WIDTH=8 instance, MULTU 0xFF×0xFF → busy 10 cycles, hi=0xFE, lo=0x01. DIV 0x80/0xFF → lo=0x80, hi=0x00.

Source files
------------

// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the EX stage and the iterative
// multiply/divide unit. The pipeline side is the master.
interface mdu_iterative_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             cancel;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, rs, rt, cancel,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, rs, rt, cancel,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative HI/LO multiply/divide unit. Multiply is radix-2 shift-add on
// magnitudes, divide is restoring radix-2 on magnitudes; signs are applied
// in a single FIX cycle that also commits HI/LO atomically, so a flush
// (cancel) at any point before that edge leaves HI/LO untouched.
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    mdu_iterative_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;

    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;

    // opnd_r holds the multiplicand (MUL) or the divisor (DIV) magnitude.
    // acc_r is {partial product, multiplier} for MUL, {remainder, quotient}
    // for DIV.
    logic [WIDTH-1:0]   opnd_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [CW-1:0]      count_r;
    logic [3:0]         op_r;
    logic               neg_res_r;   // product / quotient must be negated
    logic               neg_rem_r;   // remainder takes the dividend sign

    logic               is_div_s;
    logic               rt_zero_s;
    logic               is_long_s;
    logic               accept_s;
    logic               busy_s;
    logic               is_signed_s;
    logic [WIDTH-1:0]   abs_rs_s;
    logic [WIDTH-1:0]   abs_rt_s;

    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [2*WIDTH-1:0] fix_hilo_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: one iteration per cycle, cancel aborts from any busy state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && is_long_s) begin
                    if (is_div_s) begin
                        state_next_s = DIV;
                    end else begin
                        state_next_s = MUL;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL, DIV: begin
                if (bus.cancel) begin
                    state_next_s = IDLE;
                end else if (count_r == CW'(1)) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = state_r;
                end
            end
            FIX:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs and request decode; busy has a combinational term so a
    // dependent MF* right behind the start already stalls.
    always_comb begin
        is_div_s    = (bus.op == 4'd2) || (bus.op == 4'd3);
        rt_zero_s   = (bus.rt == {WIDTH{1'b0}});
        is_long_s   = (bus.op[3] == 1'b0) && !(is_div_s && rt_zero_s);
        is_signed_s = (bus.op[0] == 1'b0);
        accept_s    = bus.start && (state_r == IDLE) && !bus.cancel;
        busy_s      = (state_r != IDLE) || (bus.start && is_long_s && !bus.cancel);
    end

    // Operand magnitudes for signed ops; unsigned ops pass through raw.
    always_comb begin
        if (is_signed_s && bus.rs[WIDTH-1]) begin
            abs_rs_s = {WIDTH{1'b0}} - bus.rs;
        end else begin
            abs_rs_s = bus.rs;
        end
        if (is_signed_s && bus.rt[WIDTH-1]) begin
            abs_rt_s = {WIDTH{1'b0}} - bus.rt;
        end else begin
            abs_rt_s = bus.rt;
        end
    end

    // One shift-add step and one restoring-divide step.
    always_comb begin
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
        // Remainder shifted left needs WIDTH+1 bits before the trial subtract.
        div_trial_s = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_r};
        if (div_trial_s[WIDTH] == 1'b0) begin
            div_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction and HI/LO merge applied in the FIX cycle.
    always_comb begin
        if (neg_res_r) begin
            prod_s = {(2*WIDTH){1'b0}} - acc_r;
            quo_s  = {WIDTH{1'b0}} - acc_r[WIDTH-1:0];
        end else begin
            prod_s = acc_r;
            quo_s  = acc_r[WIDTH-1:0];
        end
        if (neg_rem_r) begin
            rem_s = {WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH];
        end else begin
            rem_s = acc_r[2*WIDTH-1:WIDTH];
        end
        case (op_r)
            4'd2, 4'd3: fix_hilo_s = {rem_s, quo_s};
            4'd4, 4'd5: fix_hilo_s = {hi_r, lo_r} + prod_s;
            4'd6, 4'd7: fix_hilo_s = {hi_r, lo_r} - prod_s;
            default:    fix_hilo_s = prod_s;
        endcase
    end

    // Datapath registers, architectural HI/LO and the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            done_r    <= 1'b0;
            opnd_r    <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            count_r   <= {CW{1'b0}};
            op_r      <= 4'd0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
        end else begin
            done_r <= (state_r == FIX) && !bus.cancel;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        case (bus.op)
                            4'd8: hi_r <= bus.rs;
                            4'd9: lo_r <= bus.rs;
                            default: begin
                                if (is_long_s) begin
                                    op_r      <= bus.op;
                                    count_r   <= CW'(WIDTH);
                                    neg_res_r <= is_signed_s && (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
                                    neg_rem_r <= is_signed_s && bus.rs[WIDTH-1];
                                    if (is_div_s) begin
                                        opnd_r <= abs_rt_s;
                                        acc_r  <= {{WIDTH{1'b0}}, abs_rs_s};
                                    end else begin
                                        opnd_r <= abs_rs_s;
                                        acc_r  <= {{WIDTH{1'b0}}, abs_rt_s};
                                    end
                                end
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc_r   <= mul_next_s;
                    count_r <= count_r - CW'(1);
                end
                DIV: begin
                    acc_r   <= div_next_s;
                    count_r <= count_r - CW'(1);
                end
                FIX: begin
                    if (!bus.cancel) begin
                        hi_r <= fix_hilo_s[2*WIDTH-1:WIDTH];
                        lo_r <= fix_hilo_s[WIDTH-1:0];
                    end
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.done = done_r;
    assign bus.busy = busy_s;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative at WIDTH=32 and WIDTH=8.
module tb_mdu_iterative;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_iterative_if #(.WIDTH(32)) b32 ();
    mdu_iterative_if #(.WIDTH(8))  b8  ();

    mdu_iterative #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    mdu_iterative #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int errors = 0;
    int checks = 0;
    int done32 = 0;
    int done8  = 0;
    logic [63:0] mhi32, mlo32, mhi8, mlo8;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint sext(input logic [63:0] x, input int w);
        longint t;
        t = longint'(x << (64 - w));
        return t >>> (64 - w);
    endfunction

    // Architectural reference: plain integer arithmetic on w-bit HI/LO.
    function automatic void ref_model(input int w, input logic [3:0] op,
                                      input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] hi, input logic [63:0] lo,
                                      output logic [63:0] nhi, output logic [63:0] nlo);
        logic [127:0] dm128;
        logic [63:0]  wm, dm, ua, ub, p, acc, r;
        longint       sa, sb;
        wm    = (64'd1 << w) - 64'd1;
        dm128 = (128'd1 << (2 * w)) - 128'd1;
        dm    = dm128[63:0];
        ua = a & wm;
        ub = b & wm;
        sa = sext(ua, w);
        sb = sext(ub, w);
        acc = (hi << w) | lo;
        nhi = hi;
        nlo = lo;
        p = 64'd0;
        r = 64'd0;
        if (op[0] == 1'b0) p = 64'(sa * sb);
        else               p = ua * ub;
        case (op)
            4'd0, 4'd1: r = p;
            4'd4, 4'd5: r = acc + p;
            4'd6, 4'd7: r = acc - p;
            default:    r = 64'd0;
        endcase
        r = r & dm;
        case (op)
            4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: begin
                nhi = (r >> w) & wm;
                nlo = r & wm;
            end
            4'd2: if (sb != 0) begin
                nlo = 64'(sa / sb) & wm;
                nhi = 64'(sa % sb) & wm;
            end
            4'd3: if (ub != 64'd0) begin
                nlo = (ua / ub) & wm;
                nhi = (ua % ub) & wm;
            end
            4'd8: nhi = ua;
            4'd9: nlo = ua;
            default: ;
        endcase
    endfunction

    // Monitors: every done pulse consumes one expected result.
    always @(negedge clk) begin : mon32
        exp_t e;
        if (reset !== 1'b1 && b32.done === 1'b1) begin
            done32++;
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done32_unexpected: got done=1 expected no pending op");
            end else begin
                e = q32.pop_front();
                chk("sb32_hilo", {b32.hi, b32.lo}, {e.hi[31:0], e.lo[31:0]});
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (reset !== 1'b1 && b8.done === 1'b1) begin
            done8++;
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done8_unexpected: got done=1 expected no pending op");
            end else begin
                e = q8.pop_front();
                chk("sb8_hilo", {48'd0, b8.hi, b8.lo}, {48'd0, e.hi[7:0], e.lo[7:0]});
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Long op on the 32-bit unit; abort_at<0 means run to completion,
    // otherwise cancel (or reset) is raised in that cycle.
    task automatic run_long32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input int exp_busy, input int abort_at, input bit use_reset);
        int n;
        int d0;
        logic [63:0] nh, nl;
        ref_model(32, op, {32'd0, a}, {32'd0, b}, mhi32, mlo32, nh, nl);
        if (abort_at < 0) begin
            q32.push_back('{nh, nl});
            mhi32 = nh;
            mlo32 = nl;
        end
        d0 = done32;
        b32.op = op; b32.rs = a; b32.rt = b; b32.cancel = 1'b0; b32.start = 1'b1;
        #1;
        n = 0;
        while (b32.busy === 1'b1 && n < 100) begin
            n++;
            step();
            b32.start = 1'b0;
            if (use_reset) reset = (n == abort_at);
            else           b32.cancel = (n == abort_at);
            #1;
        end
        b32.cancel = 1'b0;
        reset = 1'b0;
        chk("busy_cycles32", 64'(n), 64'(exp_busy));
        if (abort_at < 0) begin
            chk("done_count32", 64'(done32), 64'(d0 + 1));
        end else begin
            chk("no_done32", 64'(done32), 64'(d0));
            if (use_reset) begin
                mhi32 = 64'd0; mlo32 = 64'd0; mhi8 = 64'd0; mlo8 = 64'd0;
                chk("rst_done", {63'd0, b32.done}, 64'd0);
            end
            chk("abort_hi", {32'd0, b32.hi}, mhi32);
            chk("abort_lo", {32'd0, b32.lo}, mlo32);
        end
    endtask

    // Single-cycle request (MT*, no-op, or a start blocked by cancel).
    task automatic short32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit with_cancel);
        logic [63:0] nh, nl;
        ref_model(32, op, {32'd0, a}, {32'd0, b}, mhi32, mlo32, nh, nl);
        if (!with_cancel) begin
            mhi32 = nh;
            mlo32 = nl;
        end
        b32.op = op; b32.rs = a; b32.rt = b; b32.cancel = with_cancel; b32.start = 1'b1;
        #1;
        chk("short_busy0", {63'd0, b32.busy}, 64'd0);
        step();
        b32.start = 1'b0;
        b32.cancel = 1'b0;
        #1;
        chk("short_busy1", {63'd0, b32.busy}, 64'd0);
        chk("short_hi", {32'd0, b32.hi}, mhi32);
        chk("short_lo", {32'd0, b32.lo}, mlo32);
    endtask

    task automatic run_long8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        int d0;
        logic [63:0] nh, nl;
        ref_model(8, op, {56'd0, a}, {56'd0, b}, mhi8, mlo8, nh, nl);
        q8.push_back('{nh, nl});
        mhi8 = nh;
        mlo8 = nl;
        d0 = done8;
        b8.op = op; b8.rs = a; b8.rt = b; b8.cancel = 1'b0; b8.start = 1'b1;
        #1;
        n = 0;
        while (b8.busy === 1'b1 && n < 100) begin
            n++;
            step();
            b8.start = 1'b0;
            #1;
        end
        chk("busy_cycles8", 64'(n), 64'd10);
        chk("done_count8", 64'(done8), 64'(d0 + 1));
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        int k;
        reset = 1'b1;
        b32.start = 1'b0; b32.op = 4'd0; b32.rs = 32'd0; b32.rt = 32'd0; b32.cancel = 1'b0;
        b8.start  = 1'b0; b8.op  = 4'd0; b8.rs  = 8'd0;  b8.rt  = 8'd0;  b8.cancel  = 1'b0;
        mhi32 = 64'd0; mlo32 = 64'd0; mhi8 = 64'd0; mlo8 = 64'd0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("rst_hi", {32'd0, b32.hi}, 64'd0);
        chk("rst_lo", {32'd0, b32.lo}, 64'd0);
        chk("rst_busy", {63'd0, b32.busy}, 64'd0);
        chk("rst_done0", {63'd0, b32.done}, 64'd0);

        // Signed multiply, full latency
        run_long32(4'd0, 32'hFFFFFFFE, 32'd3, 34, -1, 1'b0);
        chk("mult_hi", {32'd0, b32.hi}, 64'hFFFFFFFF);
        chk("mult_lo", {32'd0, b32.lo}, 64'hFFFFFFFA);

        // Signed divide, back-to-back with the previous completion
        run_long32(4'd2, 32'hFFFFFFF9, 32'd2, 34, -1, 1'b0);
        chk("div_lo", {32'd0, b32.lo}, 64'hFFFFFFFD);
        chk("div_hi", {32'd0, b32.hi}, 64'hFFFFFFFF);
        run_long32(4'd2, 32'h80000000, 32'hFFFFFFFF, 34, -1, 1'b0);
        chk("divmin_lo", {32'd0, b32.lo}, 64'h80000000);
        chk("divmin_hi", {32'd0, b32.hi}, 64'h0);
        short32(4'd3, 32'd1234, 32'd0, 1'b0);
        short32(4'd2, 32'd99, 32'd0, 1'b0);

        // Accumulating ops
        short32(4'd8, 32'd5, 32'd0, 1'b0);
        short32(4'd9, 32'd7, 32'd0, 1'b0);
        run_long32(4'd5, 32'hFFFFFFFF, 32'd2, 34, -1, 1'b0);
        chk("maddu_hi", {32'd0, b32.hi}, 64'd7);
        chk("maddu_lo", {32'd0, b32.lo}, 64'd5);
        short32(4'd8, 32'd0, 32'd0, 1'b0);
        short32(4'd9, 32'd0, 32'd0, 1'b0);
        run_long32(4'd6, 32'd1, 32'd1, 34, -1, 1'b0);
        chk("msub_hi", {32'd0, b32.hi}, 64'hFFFFFFFF);
        chk("msub_lo", {32'd0, b32.lo}, 64'hFFFFFFFF);

        // Cancel mid-op, then an op accepted in the very next cycle
        short32(4'd8, 32'h11, 32'd0, 1'b0);
        short32(4'd9, 32'h22, 32'd0, 1'b0);
        run_long32(4'd0, 32'h12345, 32'h777, 11, 10, 1'b0);
        run_long32(4'd1, 32'd3, 32'd4, 34, -1, 1'b0);
        chk("multu_lo", {32'd0, b32.lo}, 64'd12);
        chk("multu_hi", {32'd0, b32.hi}, 64'd0);

        // Cancel on the FIX cycle suppresses the commit
        run_long32(4'd4, 32'hDEADBEEF, 32'h1234, 34, 33, 1'b0);

        // Reset in the middle of a divide
        run_long32(4'd2, 32'd1000, 32'd7, 6, 5, 1'b1);

        // Start coinciding with cancel in IDLE is not accepted
        short32(4'd0, 32'd9, 32'd9, 1'b1);
        short32(4'd8, 32'hABCD, 32'd0, 1'b1);

        // Randomised mix
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 11));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            if (op < 4'd8 && !((op == 4'd2 || op == 4'd3) && b == 32'd0)) begin
                if ($urandom_range(0, 9) == 0) begin
                    k = $urandom_range(1, 33);
                    run_long32(op, a, b, k + 1, k, 1'b0);
                end else begin
                    run_long32(op, a, b, 34, -1, 1'b0);
                end
            end else begin
                short32(op, a, b, 1'b0);
            end
        end

        // Narrow instance
        run_long8(4'd1, 8'hFF, 8'hFF);
        chk("mul8_hi", {56'd0, b8.hi}, 64'hFE);
        chk("mul8_lo", {56'd0, b8.lo}, 64'h01);
        run_long8(4'd2, 8'h80, 8'hFF);
        chk("div8_lo", {56'd0, b8.lo}, 64'h80);
        chk("div8_hi", {56'd0, b8.hi}, 64'h00);
        for (int i = 0; i < 12; i++) begin
            op = 4'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (b[7:0] == 8'd0) b = 32'd1;
            run_long8(op, a[7:0], b[7:0]);
        end

        step();
        chk("q32_empty", 64'(q32.size()), 64'd0);
        chk("q8_empty", 64'(q8.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
